// File: rtl/up_bus_pkg.sv
// Shared definitions for the up-protocol bus master.
//   up_state_t : FSM state encoding
//   UP_RDLAT   : slave read latency, default drain length
//   TMO_CNT_W  : width of the timeout/drain counter and of tmo_cnt
package up_bus_pkg;

  localparam int unsigned UP_RDLAT  = 3;
  localparam int unsigned TMO_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRB,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } up_state_t;

endpackage

// File: rtl/up_tmo_cnt.sv
// Loadable up-counter with a terminal-count flag; times both the uprdy wait
// and the post-transaction drain.
//   clk, rst_n : clock, async active-low reset
//   load       : synchronous clear to 0 (wins over inc)
//   inc        : count up by one
//   last       : terminal value compared against the current count
//   tc_c       : combinational flag, count == last
module up_tmo_cnt
  import up_bus_pkg::*;
#(
  parameter int unsigned G_W = TMO_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           inc,
  input  logic [G_W-1:0] last,
  output logic           tc_c
);

  logic [G_W-1:0] cnt_q;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + G_W'(1);
    end
  end

  assign tc_c = (cnt_q == last);

endmodule

// File: rtl/up_bus_master.sv
// CPU-side up-protocol master: turns one valid/ready host request into one
// up access (upen held, one-cycle upws/uprs), waits for uprdy with a timeout,
// returns a one-cycle response, then idles upen for G_DRAIN+1 cycles.
//   host side : req_vld/req_rdy/req_wr/req_addr/req_wdata
//               rsp_vld/rsp_err/rsp_rdata, tmo_cnt/tmo_clr
//   up side   : upen/upa/upws/uprs/updi out, updo/uprdy in
// G_DRAIN must be at least 1 (and at least the slave read latency).
module up_bus_master
  import up_bus_pkg::*;
#(
  parameter int unsigned G_ADDR  = 10,
  parameter int unsigned G_WIDTH = 32,
  parameter int unsigned G_TMO   = 64,
  parameter int unsigned G_DRAIN = UP_RDLAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic                 req_wr,
  input  logic [G_ADDR-1:0]    req_addr,
  input  logic [G_WIDTH-1:0]   req_wdata,
  output logic                 rsp_vld,
  output logic                 rsp_err,
  output logic [G_WIDTH-1:0]   rsp_rdata,
  output logic [TMO_CNT_W-1:0] tmo_cnt,
  input  logic                 tmo_clr,
  output logic                 upen,
  output logic [G_ADDR-1:0]    upa,
  output logic                 upws,
  output logic                 uprs,
  output logic [G_WIDTH-1:0]   updi,
  input  logic [G_WIDTH-1:0]   updo,
  input  logic                 uprdy
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST   = TMO_CNT_W'(G_TMO - 1);
  localparam logic [TMO_CNT_W-1:0] DRAIN_LAST = TMO_CNT_W'(G_DRAIN - 1);

  up_state_t              state_q, state_d;
  logic                   req_rdy_d, upen_d, upws_d, uprs_d, rsp_vld_d, rsp_err_d;
  logic [G_ADDR-1:0]      upa_d;
  logic [G_WIDTH-1:0]     updi_d, rsp_rdata_d;
  logic [TMO_CNT_W-1:0]   tmo_cnt_d;
  logic                   cnt_load_c, cnt_inc_c, cnt_tc_c;
  logic [TMO_CNT_W-1:0]   cnt_last_c;

  // Shared counter: uprdy timeout in WAIT, drain length in DRAIN
  up_tmo_cnt #(.G_W(TMO_CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load_c),
    .inc   (cnt_inc_c),
    .last  (cnt_last_c),
    .tc_c  (cnt_tc_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    upa_d       = upa;
    updi_d      = updi;
    upws_d      = 1'b0;
    uprs_d      = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    tmo_cnt_d   = tmo_cnt;
    cnt_load_c  = 1'b0;
    cnt_inc_c   = 1'b0;
    cnt_last_c  = TMO_LAST;

    case (state_q)
      ST_IDLE: begin
        if (req_vld && req_rdy) begin
          state_d = ST_STRB;
          upa_d   = req_addr;
          updi_d  = req_wdata;
          upws_d  = req_wr;
          uprs_d  = !req_wr;
        end
      end
      ST_STRB: begin
        cnt_load_c = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_inc_c = 1'b1;
        // uprdy has priority over an expiry in the same cycle
        if (uprdy) begin
          rsp_rdata_d = updo;
          rsp_err_d   = 1'b0;
          state_d     = ST_DONE;
        end else if (cnt_tc_c) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_load_c = 1'b1;
        state_d    = ST_DRAIN;
        if (rsp_err && (tmo_cnt != '1)) begin
          tmo_cnt_d = tmo_cnt + TMO_CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // uprdy deliberately ignored: late pulses from an aborted read
        cnt_inc_c  = 1'b1;
        cnt_last_c = DRAIN_LAST;
        if (cnt_tc_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_clr) begin
      tmo_cnt_d = '0;
    end

    upen_d    = (state_d == ST_STRB) || (state_d == ST_WAIT);
    req_rdy_d = (state_d == ST_IDLE);
    rsp_vld_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_rdy   <= 1'b1;
      upen      <= 1'b0;
      upws      <= 1'b0;
      uprs      <= 1'b0;
      upa       <= '0;
      updi      <= '0;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      tmo_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      req_rdy   <= req_rdy_d;
      upen      <= upen_d;
      upws      <= upws_d;
      uprs      <= uprs_d;
      upa       <= upa_d;
      updi      <= updi_d;
      rsp_vld   <= rsp_vld_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      tmo_cnt   <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_up_bus_master.sv
// Self-checking bench for up_bus_master (G_TMO=8, default drain of 3).
// A transaction-timeline model predicts every output each cycle; directed
// transactions additionally pin literal values at fixed cycle offsets.
module tb_up_bus_master;

  localparam int TMO   = 8;
  localparam int DRAIN = 3;
  localparam int NREC  = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0, req_wr = 1'b0, tmo_clr = 1'b0, uprdy = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0, updo = '0;
  logic        req_rdy, rsp_vld, rsp_err, upen, upws, uprs;
  logic [31:0] rsp_rdata, updi;
  logic [9:0]  upa;
  logic [7:0]  tmo_cnt;

  int tests = 0;
  int fails = 0;

  up_bus_master #(.G_ADDR(10), .G_WIDTH(32), .G_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .tmo_cnt(tmo_cnt), .tmo_clr(tmo_clr),
    .upen(upen), .upa(upa), .upws(upws), .uprs(uprs), .updi(updi),
    .updo(updo), .uprdy(uprdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // One transaction: accepted in cycle t0, strobe in t0+1, WAIT window
  // t0+2 .. t0+1+TMO, response resolved in cycle r, DONE at r+1,
  // drain r+2 .. r+1+DRAIN, idle again at r+2+DRAIN.
  int          cyc = 0;
  bit          m_have = 0;
  int          m_t0 = 0, m_r = -1;
  bit          m_wr = 0, m_err = 0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  int          m_tmo = 0;

  function automatic bit m_rdy(input int k);
    return !(m_have && k > m_t0 && (m_r < 0 || k <= m_r + 1 + DRAIN));
  endfunction

  always @(posedge clk) begin
    int c, k;
    c = cyc;
    cyc++;
    if (!rst_n) begin
      m_have = 0; m_r = -1; m_addr = '0; m_wdata = '0; m_tmo = 0; m_err = 0;
    end else begin
      if (m_rdy(c) && req_vld) begin
        m_have = 1; m_t0 = c; m_r = -1;
        m_wr = req_wr; m_addr = req_addr; m_wdata = req_wdata;
      end else if (m_have && m_r < 0 && c >= m_t0 + 2) begin
        if (uprdy) begin
          m_r = c; m_err = 0; m_rdata = updo;
        end else if (c == m_t0 + 1 + TMO) begin
          m_r = c; m_err = 1; m_rdata = '0;
        end
      end
      if (tmo_clr) m_tmo = 0;
      else if (m_have && m_r >= 0 && m_err && c == m_r + 1 && m_tmo < 255) m_tmo++;
      k = c + 1;
      #1;
      if (rst_n) begin
        chk("req_rdy", 32'(req_rdy), 32'(m_rdy(k)));
        chk("upen", 32'(upen), 32'(m_have && k > m_t0 && (m_r < 0 || k <= m_r)));
        chk("upws", 32'(upws), 32'(m_have && k == m_t0 + 1 && m_wr));
        chk("uprs", 32'(uprs), 32'(m_have && k == m_t0 + 1 && !m_wr));
        chk("rsp_vld", 32'(rsp_vld), 32'(m_have && m_r >= 0 && k == m_r + 1));
        chk("upa", 32'(upa), 32'(m_addr));
        chk("updi", updi, m_wdata);
        chk("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
        if (m_have && m_r >= 0 && k == m_r + 1) begin
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
          chk("rsp_rdata", rsp_rdata, m_rdata);
        end
      end
    end
  end

  // ---------------- driver / recorder ----------------
  logic        rec_rdy [NREC], rec_upen [NREC], rec_upws [NREC], rec_uprs [NREC];
  logic        rec_vld [NREC], rec_err [NREC];
  logic [31:0] rec_rdata [NREC], rec_updi [NREC];
  logic [9:0]  rec_upa [NREC];
  logic [7:0]  rec_tmo [NREC];

  // Called at a negedge. k indexes cycles from the accept cycle T0.
  // dly: uprdy at T(1+dly), 0 = never. stray: extra uprdy at Tstray (0 = none).
  task automatic do_txn(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                        input int dly, input logic [31:0] rdata, input int stray,
                        input int clr_k, output int last);
    int n;
    n = 0;
    while (!req_rdy && n < 64) begin @(negedge clk); n++; end
    last = -1;
    for (int k = 0; k < NREC; k++) begin
      if (k > 0) @(negedge clk);
      rec_rdy[k] = req_rdy; rec_upen[k] = upen; rec_upws[k] = upws; rec_uprs[k] = uprs;
      rec_vld[k] = rsp_vld; rec_err[k] = rsp_err; rec_rdata[k] = rsp_rdata;
      rec_upa[k] = upa; rec_updi[k] = updi; rec_tmo[k] = tmo_cnt;
      if (k > 1 && req_rdy) begin last = k; break; end
      req_vld = (k == 0);
      if (k == 0) begin req_wr = wr; req_addr = addr; req_wdata = wdata; end
      uprdy   = (dly > 0 && k == 1 + dly) || (stray > 0 && k == stray);
      updo    = uprdy ? rdata : $urandom();
      tmo_clr = (k == clr_k);
    end
    req_vld = 0; uprdy = 0; tmo_clr = 0;
    if (last < 0) begin
      tests++; fails++;
      $display("FAIL txn_bound: got no return to idle expected return within %0d cycles", NREC);
      last = NREC - 1;
    end
  endtask

  function automatic int ones_upws(input int last);
    int s = 0;
    for (int i = 0; i <= last; i++) s += int'(rec_upws[i]);
    return s;
  endfunction

  function automatic int ones_uprs(input int last);
    int s = 0;
    for (int i = 0; i <= last; i++) s += int'(rec_uprs[i]);
    return s;
  endfunction

  function automatic int ones_vld(input int last);
    int s = 0;
    for (int i = 0; i <= last; i++) s += int'(rec_vld[i]);
    return s;
  endfunction

  initial begin
    int last;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_upen", 32'(upen), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Write, uprdy at T4
    do_txn(1'b1, 10'h005, 32'hDEADBEEF, 3, 32'h0, 0, -1, last);
    chk("w_upws_T1", 32'(rec_upws[1]), 32'd1);
    chk("w_upws_once", 32'(ones_upws(last)), 32'd1);
    chk("w_upa_T1", 32'(rec_upa[1]), 32'h005);
    chk("w_updi_T1", rec_updi[1], 32'hDEADBEEF);
    chk("w_upen_T1", 32'(rec_upen[1]), 32'd1);
    chk("w_upen_T4", 32'(rec_upen[4]), 32'd1);
    chk("w_upen_T5", 32'(rec_upen[5]), 32'd0);
    chk("w_vld_T5", 32'(rec_vld[5]), 32'd1);
    chk("w_err_T5", 32'(rec_err[5]), 32'd0);
    chk("w_rdy_T8", 32'(rec_rdy[8]), 32'd0);
    chk("w_idle_at", 32'(last), 32'd9);

    // Read 0x3FF, uprdy at T7
    do_txn(1'b0, 10'h3FF, 32'h0, 6, 32'h12345678, 0, -1, last);
    chk("r_uprs_T1", 32'(rec_uprs[1]), 32'd1);
    chk("r_uprs_once", 32'(ones_uprs(last)), 32'd1);
    chk("r_vld_T8", 32'(rec_vld[8]), 32'd1);
    chk("r_rdata_T8", rec_rdata[8], 32'h12345678);
    chk("r_err_T8", 32'(rec_err[8]), 32'd0);

    // Timeout, stray uprdy two cycles into drain
    do_txn(1'b0, 10'h123, 32'h0, 0, 32'hCAFEF00D, 12, -1, last);
    chk("t_upen_T9", 32'(rec_upen[9]), 32'd1);
    chk("t_upen_T10", 32'(rec_upen[10]), 32'd0);
    chk("t_vld_T10", 32'(rec_vld[10]), 32'd1);
    chk("t_err_T10", 32'(rec_err[10]), 32'd1);
    chk("t_rdata_T10", rec_rdata[10], 32'h0);
    chk("t_tmo_after", 32'(rec_tmo[last]), 32'd1);
    chk("t_one_vld", 32'(ones_vld(last)), 32'd1);
    chk("t_idle_at", 32'(last), 32'd14);

    // uprdy on the exact expiry cycle
    do_txn(1'b0, 10'h0AA, 32'h0, TMO, 32'hA5A5_0F0F, 0, -1, last);
    chk("e_vld_T10", 32'(rec_vld[10]), 32'd1);
    chk("e_err_T10", 32'(rec_err[10]), 32'd0);
    chk("e_rdata_T10", rec_rdata[10], 32'hA5A5_0F0F);
    chk("e_tmo_same", 32'(rec_tmo[last]), 32'd1);

    // 260 timeouts saturate, then clear on a DONE cycle
    for (int i = 0; i < 260; i++) do_txn(1'b0, 10'(i), 32'h0, 0, 32'h0, 0, -1, last);
    chk("sat_tmo", 32'(tmo_cnt), 32'd255);
    do_txn(1'b0, 10'h001, 32'h0, 0, 32'h0, 0, 10, last);
    chk("clr_tmo_T10", 32'(rec_tmo[10]), 32'd255);
    chk("clr_err_T10", 32'(rec_err[10]), 32'd1);
    chk("clr_tmo_after", 32'(rec_tmo[last]), 32'd0);

    // Reset during WAIT
    req_vld = 1; req_wr = 0; req_addr = 10'h055;
    @(negedge clk); req_vld = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mr_upen", 32'(upen), 32'd0);
    chk("mr_upws", 32'(upws), 32'd0);
    chk("mr_uprs", 32'(uprs), 32'd0);
    chk("mr_rsp_vld", 32'(rsp_vld), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mr_req_rdy", 32'(req_rdy), 32'd1);
    do_txn(1'b0, 10'h2C3, 32'h0, 3, 32'h0BADF00D, 0, -1, last);
    chk("mr_vld_T5", 32'(rec_vld[5]), 32'd1);
    chk("mr_rdata_T5", rec_rdata[5], 32'h0BADF00D);
    chk("mr_err_T5", 32'(rec_err[5]), 32'd0);

    // Randomized traffic, stray uprdy in idle, sporadic tmo_clr
    for (int i = 0; i < 150; i++) begin
      int gap, dly, stray, clr;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        uprdy = 1'($urandom_range(0, 1)); updo = $urandom(); tmo_clr = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      uprdy = 0; tmo_clr = 0;
      dly   = $urandom_range(0, TMO + 3);
      stray = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
      clr   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : -1;
      do_txn(1'($urandom_range(0, 1)), 10'($urandom()), $urandom(), dly, $urandom(), stray, clr, last);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/up_bus_master.md
Name: up_bus_master

Overview:
- CPU-side master for the up protocol. It converts a single-beat host request (valid/ready) into one up transaction: upen held for the whole access, upws or uprs strobed for one cycle.
- It waits for uprdy, which arrives at least 3 cycles after the strobe, captures updo, and returns a response.
- It sits directly upstream of config-RAM macros and register blocks that follow the up protocol.
- It enforces a timeout. On expiry it deasserts upen, which aborts the slave's pending read latch, and flags an error.

Parameters:
- G_ADDR, 10, up address width.
- G_WIDTH, 32, up data width.
- G_TMO, 64, maximum cycles to wait for uprdy after the strobe cycle. Legal range is 4..255.
- G_DRAIN, 3, idle cycles after each transaction. It must be ≥ the slave's read latency.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  host request valid
- req_rdy  out  1  block can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  G_ADDR  request address
- req_wdata  in  G_WIDTH  write data
- rsp_vld  out  1  one-cycle response pulse
- rsp_err  out  1  timeout; qualified by rsp_vld
- rsp_rdata  out  G_WIDTH  read data; qualified by rsp_vld
- tmo_cnt  out  8  saturating count of timeouts
- tmo_clr  in  1  synchronous clear of tmo_cnt
- upen  out  1  up enable
- upa  out  G_ADDR  up address
- upws  out  1  write strobe
- uprs  out  1  read strobe
- updi  out  G_WIDTH  up write data
- updo  in  G_WIDTH  up read data, valid while uprdy=1
- uprdy  in  1  up access done

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: every output is registered and resets to 0, except req_rdy, which resets to 1. The FSM resets to IDLE.
- IDLE state:
  - req_rdy=1.
  - On req_vld & req_rdy, latch req_wr, req_addr and req_wdata into upa/updi and go to STRB.
- STRB state (exactly 1 cycle):
  - upen=1.
  - upws=req_wr and uprs=!req_wr, taken from the latched request.
  - Timeout counter loads 0.
  - Go to WAIT.
- WAIT state:
  - upen=1, upws=uprs=0; upa and updi are held.
  - Counter increments each cycle.
  - If uprdy=1, capture rsp_rdata<=updo (for writes as well) and set rsp_err<=0, then go to DONE.
  - Else, if the counter reaches G_TMO-1, set rsp_err<=1, keep rsp_rdata at 0, and go to DONE.
  - If uprdy and expiry coincide, uprdy wins and the access is not an error.
- DONE state (1 cycle):
  - upen=0.
  - rsp_vld=1 for this cycle only.
  - If rsp_err, tmo_cnt increments, saturating at 255.
  - Go to DRAIN.
- DRAIN state (G_DRAIN cycles):
  - upen=0, req_rdy=0.
  - uprdy is ignored, because late pipeline pulses from an aborted access can still arrive here.
  - Then go to IDLE.
- req_rdy is 1 only in IDLE. The host must hold its request until it is accepted.
- Nominal latency, uncontended read:
  - Accept at T0.
  - STRB at T1.
  - uprdy at T4.
  - rsp_vld at T5.
  - req_rdy again at T5+G_DRAIN+1 (T9 for the default).
- Strobes are never asserted for more than 1 cycle per transaction. upen is 0 for at least G_DRAIN+1 cycles between transactions, which clears any slave read latch.
- An uprdy seen in IDLE is ignored.
- tmo_cnt:
  - tmo_clr resets it to 0.
  - If tmo_clr and an increment coincide, the result is 0.
- Reset mid-transaction: upen and the strobes drop asynchronously, no response is issued, and the FSM returns to IDLE.

Decomposition:
- Shared package up_bus_pkg holds:
  - the FSM state encoding (IDLE, STRB, WAIT, DONE, DRAIN);
  - the UP_RDLAT=3 constant, used as the G_DRAIN default;
  - the tmo_cnt width (8).
- One natural sub-module: up_tmo_cnt. It is a loadable up-counter with a terminal-count flag, and it is reused to count the DRAIN cycles.

Test Plan:
- Write, addr=0x005, data=0xDEADBEEF, slave returns uprdy at T4.
  - Required: upws high only at T1; upen high T1..T4; rsp_vld at T5 with rsp_err=0; req_rdy=1 at T9.
- Read, addr=0x3FF, slave returns uprdy at T7 with updo=0x12345678.
  - Required: uprs high only at T1; rsp_vld at T8 with rsp_rdata=0x12345678 and rsp_err=0.
- Read with no uprdy, G_TMO=8.
  - Required: upen deasserts after T9; rsp_vld=1 with rsp_err=1 and rsp_rdata=0; tmo_cnt=1.
  - Then inject a stray uprdy 2 cycles into DRAIN. Required: no second rsp_vld.
- uprdy on the exact expiry cycle.
  - Required: rsp_err=0 and data captured; tmo_cnt unchanged.
- 260 consecutive timeouts.
  - Required: tmo_cnt saturates at 255.
  - Then assert tmo_clr on a timeout DONE cycle. Required: tmo_cnt=0.
- Assert rst_n=0 during WAIT.
  - Required: upen, upws, uprs and rsp_vld are all 0 immediately; req_rdy=1 after release; a new read completes normally.
